// File: rtl/usb_utmi_pkg.sv
// Shared UTMI-side types and constants: byte bus type, tx arbiter state
// encoding and the default inter-packet gap length.
package usb_utmi_pkg;

    typedef logic [7:0] bus8_t;

    // 8 full-speed bit times at 4 clk per bit
    localparam int USB_IPG_CLKS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } usb_tx_arb_state_t;

    // Round-robin successor of idx among n slots.
    function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/usb_tx_arb_if.sv
// Bundle between packet sources / UTM tx port and the tx arbiter.
// master = arbiter side, slave = sources plus UTM side.
interface usb_tx_arb_if
    import usb_utmi_pkg::*;
#(
    parameter int REQ_N = 3
);
    logic                    arb_en;
    logic [REQ_N-1:0]        req_valid;
    bus8_t [REQ_N-1:0]       req_data;
    logic [REQ_N-1:0]        req_last;
    logic [REQ_N-1:0]        req_ready;
    logic [REQ_N-1:0]        grant;
    bus8_t                   data_in;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    utm_tx_oen;
    logic                    busy;
    logic                    underrun;

    modport master (
        input  arb_en, req_valid, req_data, req_last, tx_ready, utm_tx_oen,
        output req_ready, grant, data_in, tx_valid, busy, underrun
    );

    modport slave (
        output arb_en, req_valid, req_data, req_last, tx_ready, utm_tx_oen,
        input  req_ready, grant, data_in, tx_valid, busy, underrun
    );
endinterface

// File: rtl/usb_rr_arb.sv
// Generic round-robin picker: one-hot winner among requesters at or after the
// pointer (wrapping); the pointer moves past the winner when advance is taken.
module usb_rr_arb
    import usb_utmi_pkg::*;
#(
    parameter int REQ_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] i_req,
    input  logic             i_en,
    input  logic             i_advance,
    output logic [REQ_N-1:0] o_winner
);
    localparam int PW = (REQ_N > 1) ? $clog2(REQ_N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_hi_idx;
    logic [PW-1:0] w_lo_idx;
    logic [PW-1:0] w_win_idx;
    logic          w_hi_found;
    logic          w_lo_found;

    // Lowest requester at/above the pointer, else lowest overall (wrap).
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_lo_idx   = PW'(i);
                w_lo_found = 1'b1;
                if (PW'(i) >= r_ptr) begin
                    w_hi_idx   = PW'(i);
                    w_hi_found = 1'b1;
                end else begin
                    w_hi_idx   = w_hi_idx;
                end
            end else begin
                w_lo_idx = w_lo_idx;
            end
        end
        w_win_idx = w_hi_found ? w_hi_idx : w_lo_idx;
        o_winner  = '0;
        if (i_en && w_lo_found) begin
            o_winner[w_win_idx] = 1'b1;
        end else begin
            o_winner = '0;
        end
    end

    // Pointer register: moves one past the taken winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && i_en && w_lo_found) begin
            r_ptr <= PW'(rr_next_idx(32'(w_win_idx), 32'(REQ_N)));
        end else begin
            r_ptr <= r_ptr;
        end
    end
endmodule

// File: rtl/usb_tx_arb.sv
// Packet-level round-robin scheduler for the UTMI tx port.
// Optional inter-packet gap state/counter: define USB_TX_ARB_IPG_EN.
module usb_tx_arb
    import usb_utmi_pkg::*;
#(
    parameter int REQ_N    = 3,
    parameter int IPG_CLKS = USB_IPG_CLKS
) (
    input  logic           clk,
    input  logic           rst,
    usb_tx_arb_if.master   io_arb
);
    if (REQ_N < 2 || REQ_N > 8 || IPG_CLKS < 1) begin : g_bad_param
        $error("usb_tx_arb: REQ_N must be 2..8 and IPG_CLKS >= 1");
    end

    usb_tx_arb_state_t r_state;
    usb_tx_arb_state_t w_next_state;
    logic [REQ_N-1:0]  r_grant;
    logic [REQ_N-1:0]  w_winner;
    logic              r_seen_oen;
    logic              w_advance;
    logic              w_own_valid;
    logic              w_own_last;
    logic              w_strobe;
    logic              w_under;
    logic              w_pkt_end;
    bus8_t             w_mux;

`ifdef USB_TX_ARB_IPG_EN
    localparam int GW = (IPG_CLKS > 1) ? $clog2(IPG_CLKS) : 1;
    logic [GW-1:0] r_gap_cnt;
`endif

    usb_rr_arb #(.REQ_N(REQ_N)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     (io_arb.req_valid),
        .i_en      (io_arb.arb_en && (r_state == IDLE)),
        .i_advance (w_advance),
        .o_winner  (w_winner)
    );

    // Only the owner's request lines matter outside IDLE.
    assign w_own_valid = |(io_arb.req_valid & r_grant);
    assign w_own_last  = |(io_arb.req_last  & r_grant);
    assign w_strobe    = (r_state == XFER) && io_arb.tx_ready;
    assign w_under     = w_strobe && !w_own_valid;
    assign w_pkt_end   = w_strobe && (!w_own_valid || w_own_last);

    // One-hot AND-OR byte mux from the owning source.
    always_comb begin
        w_mux = 8'h00;
        for (int i = 0; i < REQ_N; i++) begin
            w_mux = w_mux | (io_arb.req_data[i] & {8{r_grant[i]}});
        end
    end

    // Next-state logic for the packet scheduler.
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_arb.arb_en && (|io_arb.req_valid)) begin
                    w_next_state = XFER;
                    w_advance    = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            XFER: begin
                if (w_pkt_end) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = XFER;
                end
            end
            DRAIN: begin
                // Wait for the line to have been driven and released back to J.
                if (r_seen_oen && !io_arb.utm_tx_oen) begin
`ifdef USB_TX_ARB_IPG_EN
                    w_next_state = GAP;
`else
                    w_next_state = IDLE;
`endif
                end else begin
                    w_next_state = DRAIN;
                end
            end
            GAP: begin
`ifdef USB_TX_ARB_IPG_EN
                if (r_gap_cnt == '0) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = GAP;
                end
`else
                w_next_state = IDLE;
`endif
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, grant and line-activity flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_seen_oen <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && (w_next_state == XFER)) begin
                r_grant <= w_winner;
            end else if ((r_state == DRAIN) && (w_next_state != DRAIN)) begin
                r_grant <= '0;
            end else begin
                r_grant <= r_grant;
            end
            if (r_state == XFER) begin
                r_seen_oen <= 1'b0;
            end else if ((r_state == DRAIN) && io_arb.utm_tx_oen) begin
                r_seen_oen <= 1'b1;
            end else begin
                r_seen_oen <= r_seen_oen;
            end
        end
    end

`ifdef USB_TX_ARB_IPG_EN
    // Gap counter: held at its load value through DRAIN, counts down in GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap_cnt <= '0;
        end else if (r_state == DRAIN) begin
            r_gap_cnt <= GW'(IPG_CLKS - 1);
        end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
        end else begin
            r_gap_cnt <= r_gap_cnt;
        end
    end
`endif

    assign io_arb.grant     = r_grant;
    assign io_arb.tx_valid  = (r_state == XFER);
    assign io_arb.busy      = (r_state != IDLE);
    assign io_arb.data_in   = (r_state == XFER) ? w_mux : 8'h00;
    assign io_arb.req_ready = (w_strobe && w_own_valid) ? r_grant : '0;
    assign io_arb.underrun  = w_under;
endmodule

// File: tb/tb_usb_tx_arb.sv
// Randomized bench for usb_tx_arb: packet queues per source, a UTM line model
// and a packet-level scheduling reference model.
module tb_usb_tx_arb;
    import usb_utmi_pkg::*;

    localparam int REQ_N = 3;
    localparam int IPG   = 32;
    localparam int NPKT  = 6;
    localparam int MAXB  = 4;
`ifdef USB_TX_ARB_IPG_EN
    localparam int GAP_EXP = IPG;
`else
    localparam int GAP_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_tx_arb_if #(.REQ_N(REQ_N)) arb_if ();

    usb_tx_arb #(.REQ_N(REQ_N), .IPG_CLKS(IPG)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (arb_if.master)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Source packet store
    logic [7:0] pk_data [REQ_N][NPKT][MAXB];
    int         pk_len  [REQ_N][NPKT];
    bit         pk_drop_used [REQ_N][NPKT];
    int         head [REQ_N];
    int         bidx [REQ_N];

    // Reference model state: phase 0 idle, 1 sending, 2 waiting for line, 3 gap
    int m_phase, m_ptr, m_owner, m_gap_left, drop_at;
    bit m_seen;
    // UTM line model
    bit oen, line_busy;
    int rise_cnt, fall_cnt;
    int pkts_done;
    bit rst_done;

    function automatic logic [REQ_N-1:0] src_valid();
        logic [REQ_N-1:0] v;
        for (int s = 0; s < REQ_N; s++) begin
            v[s] = (head[s] < NPKT) &&
                   !((m_phase == 1) && (s == m_owner) && (bidx[s] == drop_at));
        end
        return v;
    endfunction

    function automatic int rr_pick(input logic [REQ_N-1:0] v, input int ptr);
        for (int k = 0; k < REQ_N; k++) begin
            if (v[(ptr + k) % REQ_N]) return (ptr + k) % REQ_N;
        end
        return 0;
    endfunction

    task automatic drive_sources();
        logic [REQ_N-1:0] v;
        v = src_valid();
        arb_if.req_valid = v;
        for (int s = 0; s < REQ_N; s++) begin
            if (head[s] < NPKT) begin
                arb_if.req_data[s] = pk_data[s][head[s]][bidx[s]];
                arb_if.req_last[s] = (bidx[s] == pk_len[s][head[s]] - 1);
            end else begin
                arb_if.req_data[s] = 8'h00;
                arb_if.req_last[s] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_owner = 0; m_gap_left = 0; drop_at = -1; m_seen = 0;
        oen = 0; line_busy = 0; rise_cnt = 0; fall_cnt = 0;
        for (int s = 0; s < REQ_N; s++) bidx[s] = 0;
    endtask

    initial begin
        logic [REQ_N-1:0] vld;
        int  cyc;
        int  ph_now;
        int  o;
        bit  skip_wait;
        bit  done;

        for (int s = 0; s < REQ_N; s++) begin
            head[s] = 0;
            for (int p = 0; p < NPKT; p++) begin
                pk_len[s][p] = $urandom_range(1, MAXB);
                pk_drop_used[s][p] = 1'b0;
                for (int b = 0; b < MAXB; b++) pk_data[s][p][b] = 8'($urandom_range(0, 255));
            end
        end
        pk_len[0][0] = 3;
        pk_data[0][0][0] = 8'hC3; pk_data[0][0][1] = 8'h11; pk_data[0][0][2] = 8'h22;
        pk_drop_used[0][0] = 1'b1;
        pk_len[1][0] = 1; pk_data[1][0][0] = 8'hD2;
        model_reset();
        pkts_done = 0; rst_done = 0;

        rst = 1'b1;
        arb_if.arb_en = 1'b1;
        arb_if.tx_ready = 1'b1;
        arb_if.utm_tx_oen = 1'b0;
        drive_sources();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 32'(arb_if.grant), 32'd0);
        chk("rst_tx_valid", 32'(arb_if.tx_valid), 32'd0);
        chk("rst_data_in", 32'(arb_if.data_in), 32'd0);
        chk("rst_busy", 32'(arb_if.busy), 32'd0);
        chk("rst_req_ready", 32'(arb_if.req_ready), 32'd0);
        chk("rst_underrun", 32'(arb_if.underrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        skip_wait = 1'b1;
        done = 1'b0;

        for (cyc = 0; cyc < 30000 && !done; cyc++) begin
            if (!skip_wait) @(negedge clk);
            skip_wait = 1'b0;

            arb_if.tx_ready   = ($urandom_range(0, 3) == 0);
            arb_if.utm_tx_oen = oen;
            if ($urandom_range(0, 19) == 0) arb_if.arb_en = ~arb_if.arb_en;
            drive_sources();
            #1;
            vld = src_valid();
            ph_now = m_phase;
            o = m_owner;

            // Asynchronous reset in the middle of a packet's second byte
            if (!rst_done && m_phase == 1 && bidx[o] == 1 && pkts_done >= 2 && !arb_if.tx_ready) begin
                #2 rst = 1'b1;
                #1;
                chk("async_rst_tx_valid", 32'(arb_if.tx_valid), 32'd0);
                chk("async_rst_grant", 32'(arb_if.grant), 32'd0);
                chk("async_rst_busy", 32'(arb_if.busy), 32'd0);
                chk("async_rst_req_ready", 32'(arb_if.req_ready), 32'd0);
                rst_done = 1'b1;
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                skip_wait = 1'b1;
                continue;
            end

            case (ph_now)
                0: begin
                    chk("idle_busy", 32'(arb_if.busy), 32'd0);
                    chk("idle_grant", 32'(arb_if.grant), 32'd0);
                    chk("idle_tx_valid", 32'(arb_if.tx_valid), 32'd0);
                    if (arb_if.arb_en && (|vld)) begin
                        m_owner = rr_pick(vld, m_ptr);
                        m_ptr = (m_owner + 1) % REQ_N;
                        m_phase = 1;
                        if (pk_len[m_owner][head[m_owner]] >= 2 && !pk_drop_used[m_owner][head[m_owner]]
                            && $urandom_range(0, 2) == 0)
                            drop_at = $urandom_range(1, pk_len[m_owner][head[m_owner]] - 1);
                        else
                            drop_at = -1;
                    end
                    if (head[0] >= NPKT && head[1] >= NPKT && head[2] >= NPKT) done = 1'b1;
                end
                1: begin
                    chk("xfer_grant", 32'(arb_if.grant), 32'(1 << o));
                    chk("xfer_tx_valid", 32'(arb_if.tx_valid), 32'd1);
                    chk("xfer_busy", 32'(arb_if.busy), 32'd1);
                    if (vld[o]) chk("xfer_data_in", 32'(arb_if.data_in), 32'(pk_data[o][head[o]][bidx[o]]));
                    if (arb_if.tx_ready) begin
                        if (vld[o]) begin
                            chk("accept_req_ready", 32'(arb_if.req_ready), 32'(1 << o));
                            chk("accept_underrun", 32'(arb_if.underrun), 32'd0);
                            if (!line_busy) begin
                                line_busy = 1'b1;
                                rise_cnt = $urandom_range(1, 4);
                            end
                            if (bidx[o] == pk_len[o][head[o]] - 1) begin
                                head[o]++;
                                bidx[o] = 0;
                                pkts_done++;
                                m_phase = 2;
                                m_seen = 1'b0;
                            end else begin
                                bidx[o]++;
                            end
                        end else begin
                            chk("underrun_pulse", 32'(arb_if.underrun), 32'd1);
                            chk("underrun_req_ready", 32'(arb_if.req_ready), 32'd0);
                            pk_drop_used[o][head[o]] = 1'b1;
                            bidx[o] = 0;
                            drop_at = -1;
                            m_phase = 2;
                            m_seen = 1'b0;
                        end
                    end else begin
                        chk("wait_req_ready", 32'(arb_if.req_ready), 32'd0);
                        chk("wait_underrun", 32'(arb_if.underrun), 32'd0);
                    end
                end
                2: begin
                    chk("drain_tx_valid", 32'(arb_if.tx_valid), 32'd0);
                    chk("drain_grant", 32'(arb_if.grant), 32'(1 << o));
                    chk("drain_busy", 32'(arb_if.busy), 32'd1);
                    if (m_seen && !oen) begin
                        m_gap_left = GAP_EXP;
                        m_phase = (GAP_EXP > 0) ? 3 : 0;
                    end else if (oen) begin
                        m_seen = 1'b1;
                    end
                end
                default: begin
                    chk("gap_busy", 32'(arb_if.busy), 32'd1);
                    chk("gap_grant", 32'(arb_if.grant), 32'd0);
                    chk("gap_tx_valid", 32'(arb_if.tx_valid), 32'd0);
                    m_gap_left--;
                    if (m_gap_left == 0) m_phase = 0;
                end
            endcase

            // UTM line: oen rises a few clk after first load, falls a few clk after tx_valid drops
            if (fall_cnt > 0) begin
                fall_cnt--;
                if (fall_cnt == 0) begin
                    oen = 1'b0;
                    line_busy = 1'b0;
                end
            end else if (line_busy && oen && ph_now == 2) begin
                fall_cnt = $urandom_range(3, 10);
            end
            if (rise_cnt > 0) begin
                rise_cnt--;
                if (rise_cnt == 0) oen = 1'b1;
            end
        end

        chk("all_packets_sent", 32'(done), 32'd1);
        chk("mid_packet_reset_hit", 32'(rst_done), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
